// File: rtl/io_bank_pkg.sv
// Shared types, constants and the per-pin pad-drive helper for the IO bank arbiter.
package io_bank_pkg;

   // Arbitration FSM states.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwn0 = 2'd1,
      StOwn1 = 2'd2,
      StTurn = 2'd3
   } arb_state_e;

   // Width of the turnaround counter; covers TURN_CYCLES up to 15.
   localparam int unsigned TURN_CNT_W = 4;

   // Per-pin IOBUF drive. Returns {t, i}.
   // An open-drain pin only ever drives low.
   // It releases to high-Z for a logic 1 or when not enabled.
   function automatic logic [1:0] pad_drive(input logic oe, input logic dout, input logic od);
      logic t;
      logic i;
      i = dout & ~od;
      t = ~(oe & ~(od & dout));
      return {t, i};
   endfunction

endpackage

// File: rtl/io_sync.sv
// N-bit multi-stage flop chain that brings asynchronous pad inputs into the clk domain.
module io_sync #(
   parameter int unsigned N      = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [N-1:0] stage_q [STAGES];

   // Shift the pad sample one stage per clock; synchronous clear to zero.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int s = 0; s < STAGES; s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         stage_q[0] <= d;
         for (int s = 1; s < STAGES; s++) begin
            stage_q[s] <= stage_q[s-1];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/io_bank_arbiter.sv
// Two-requester owner arbiter for a bank of IOBUF pads.
// It provides tristate turnaround between owners, per-pin open-drain and synchronised input data.
module io_bank_arbiter
   import io_bank_pkg::*;
#(
   parameter int unsigned     WIDTH       = 8,
   parameter int unsigned     TURN_CYCLES = 2,
   parameter int unsigned     HOLD_LIMIT  = 0,
   parameter logic [WIDTH-1:0] OD_MASK    = '0,
   parameter int unsigned     SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0,
   output logic             gnt0,
   input  logic [WIDTH-1:0] oe0,
   input  logic [WIDTH-1:0] do0,
   input  logic             req1,
   output logic             gnt1,
   input  logic [WIDTH-1:0] oe1,
   input  logic [WIDTH-1:0] do1,
   output logic [WIDTH-1:0] di,
   output logic [WIDTH-1:0] pad_i,
   output logic [WIDTH-1:0] pad_t,
   input  logic [WIDTH-1:0] pad_o
);

   localparam int unsigned HOLD_W = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'((HOLD_LIMIT > 0) ? HOLD_LIMIT - 1 : 0);
   localparam logic [TURN_CNT_W-1:0] TURN_LAST = TURN_CNT_W'(TURN_CYCLES - 1);

   arb_state_e              state_q;
   logic                    last_q;
   logic [TURN_CNT_W-1:0]   turn_cnt_q;
   logic [HOLD_W-1:0]       hold_cnt_q;

   logic [WIDTH-1:0]        drv0_t, drv0_i;
   logic [WIDTH-1:0]        drv1_t, drv1_i;
   logic                    release0, release1;
   logic                    req_other;
   logic                    turn_pick1;

   // Per-pin pad drive for each requester, applying the open-drain mask.
   always_comb begin
      drv0_t = '1;
      drv0_i = '0;
      drv1_t = '1;
      drv1_i = '0;
      for (int b = 0; b < WIDTH; b++) begin
         {drv0_t[b], drv0_i[b]} = pad_drive(oe0[b], do0[b], OD_MASK[b]);
         {drv1_t[b], drv1_i[b]} = pad_drive(oe1[b], do1[b], OD_MASK[b]);
      end
   end

   // Forced release: the hold budget is spent and the other side is waiting.
   assign release0 = (HOLD_LIMIT != 0) && (hold_cnt_q == HOLD_MAX) && req1;
   assign release1 = (HOLD_LIMIT != 0) && (hold_cnt_q == HOLD_MAX) && req0;

   // After turnaround prefer the side that did not own last; fall back to the previous owner.
   assign req_other  = last_q ? req0 : req1;
   assign turn_pick1 = req_other ? ~last_q : last_q;

   // Arbitration FSM with registered grants, counters and pad drive.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         last_q     <= 1'b1;
         turn_cnt_q <= '0;
         hold_cnt_q <= '0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         pad_t      <= '1;
         pad_i      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               pad_t      <= '1;
               pad_i      <= '0;
               hold_cnt_q <= '0;
               if (req0 && (!req1 || last_q)) begin
                  state_q <= StOwn0;
                  gnt0    <= 1'b1;
               end else if (req1) begin
                  state_q <= StOwn1;
                  gnt1    <= 1'b1;
               end
            end
            StOwn0: begin
               if (!req0 || release0) begin
                  state_q    <= StTurn;
                  gnt0       <= 1'b0;
                  last_q     <= 1'b0;
                  turn_cnt_q <= '0;
                  pad_t      <= '1;
                  pad_i      <= '0;
               end else begin
                  pad_t <= drv0_t;
                  pad_i <= drv0_i;
                  if (hold_cnt_q != HOLD_MAX) hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            StOwn1: begin
               if (!req1 || release1) begin
                  state_q    <= StTurn;
                  gnt1       <= 1'b0;
                  last_q     <= 1'b1;
                  turn_cnt_q <= '0;
                  pad_t      <= '1;
                  pad_i      <= '0;
               end else begin
                  pad_t <= drv1_t;
                  pad_i <= drv1_i;
                  if (hold_cnt_q != HOLD_MAX) hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            StTurn: begin
               pad_t      <= '1;
               pad_i      <= '0;
               hold_cnt_q <= '0;
               if (turn_cnt_q == TURN_LAST) begin
                  if (req0 || req1) begin
                     if (turn_pick1) begin
                        state_q <= StOwn1;
                        gnt1    <= 1'b1;
                     end else begin
                        state_q <= StOwn0;
                        gnt0    <= 1'b1;
                     end
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  turn_cnt_q <= turn_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   io_sync #(
      .N      (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_di_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pad_o),
      .q       (di)
   );

endmodule

// File: tb/tb_io_bank_arbiter.sv
// Scoreboard bench for io_bank_arbiter.
// Instance A uses the default configuration; instance B uses HOLD_LIMIT=4 and OD_MASK=01.
module tb_io_bank_arbiter;

   logic       clk = 1'b0;
   logic       reset_n, req0, req1;
   logic [7:0] oe0, do0, oe1, do1, pad_o;

   logic       a_gnt0, a_gnt1, b_gnt0, b_gnt1;
   logic [7:0] a_di, a_pad_i, a_pad_t, b_di, b_pad_i, b_pad_t;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit run   = 1'b0;

   localparam int S_A_GNT0 = 0, S_A_GNT1 = 1, S_A_PADT = 2, S_A_PADI = 3, S_A_DI = 4;
   localparam int S_B_GNT0 = 5, S_B_GNT1 = 6, S_B_PADT = 7, S_B_PADI = 8;

   typedef struct {
      int         due;
      int         sig;
      logic [7:0] val;
      string      tag;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   io_bank_arbiter #(
      .WIDTH(8), .TURN_CYCLES(2), .HOLD_LIMIT(0), .OD_MASK(8'h00), .SYNC_STAGES(2)
   ) dut_a (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .gnt0(a_gnt0), .oe0(oe0), .do0(do0),
      .req1(req1), .gnt1(a_gnt1), .oe1(oe1), .do1(do1),
      .di(a_di), .pad_i(a_pad_i), .pad_t(a_pad_t), .pad_o(pad_o)
   );

   io_bank_arbiter #(
      .WIDTH(8), .TURN_CYCLES(2), .HOLD_LIMIT(4), .OD_MASK(8'h01), .SYNC_STAGES(2)
   ) dut_b (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .gnt0(b_gnt0), .oe0(oe0), .do0(do0),
      .req1(req1), .gnt1(b_gnt1), .oe1(oe1), .do1(do1),
      .di(b_di), .pad_i(b_pad_i), .pad_t(b_pad_t), .pad_o(pad_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Queue an expectation dly edges from now, kept sorted by due cycle.
   task automatic expect_at(input int dly, input int sig, input logic [7:0] val, input string tag);
      exp_t e;
      int   pos;
      e.due = cyc + dly;
      e.sig = sig;
      e.val = val;
      e.tag = tag;
      pos = sb.size();
      while (pos > 0 && sb[pos-1].due > e.due) pos--;
      sb.insert(pos, e);
   endtask

   function automatic logic [7:0] sample(input int sig);
      case (sig)
         S_A_GNT0: return {7'd0, a_gnt0};
         S_A_GNT1: return {7'd0, a_gnt1};
         S_A_PADT: return a_pad_t;
         S_A_PADI: return a_pad_i;
         S_A_DI:   return a_di;
         S_B_GNT0: return {7'd0, b_gnt0};
         S_B_GNT1: return {7'd0, b_gnt1};
         S_B_PADT: return b_pad_t;
         S_B_PADI: return b_pad_i;
         default:  return 8'hxx;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Compare due expectations and grant exclusivity on the falling edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (run) begin
         chk("mutex_a", {31'd0, a_gnt0 & a_gnt1}, 32'd0);
         chk("mutex_b", {31'd0, b_gnt0 & b_gnt1}, 32'd0);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, {24'd0, sample(e.sig)}, {24'd0, e.val});
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      req0    = 1'b0;
      req1    = 1'b0;
      oe0     = '0;
      do0     = '0;
      oe1     = '0;
      do1     = '0;
      pad_o   = '0;
      tick(2);
      run = 1'b1;

      // Reset state
      expect_at(0, S_A_GNT0, 8'h00, "rst_gnt0");
      expect_at(0, S_A_GNT1, 8'h00, "rst_gnt1");
      expect_at(0, S_A_PADT, 8'hFF, "rst_pad_t");
      expect_at(0, S_A_PADI, 8'h00, "rst_pad_i");
      expect_at(0, S_A_DI,   8'h00, "rst_di");
      expect_at(0, S_B_PADT, 8'hFF, "rst_b_pad_t");

      // Single requester: grant after one edge, pads one edge later
      reset_n = 1'b1;
      req0    = 1'b1;
      oe0     = 8'hFF;
      do0     = 8'hA5;
      expect_at(1, S_A_GNT0, 8'h01, "t1_gnt0");
      expect_at(1, S_A_PADT, 8'hFF, "t1_pad_t_lat");
      expect_at(2, S_A_PADT, 8'h00, "t1_pad_t");
      expect_at(2, S_A_PADI, 8'hA5, "t1_pad_i");
      expect_at(2, S_B_PADT, 8'h01, "t1_b_od_pad_t");
      expect_at(2, S_B_PADI, 8'hA4, "t1_b_od_pad_i");
      tick(3);

      // Simultaneous requests after reset: 0 wins, then turnaround to 1
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      req0    = 1'b1;
      req1    = 1'b1;
      oe1     = 8'hFF;
      do1     = 8'h5A;
      expect_at(1, S_A_GNT0, 8'h01, "t2_gnt0");
      expect_at(1, S_A_GNT1, 8'h00, "t2_gnt1_wait");
      tick(3);
      expect_at(0, S_A_PADT, 8'h00, "t2_own0_pad_t");
      req0 = 1'b0;
      expect_at(1, S_A_GNT0, 8'h00, "t2_turn1_gnt0");
      expect_at(1, S_A_GNT1, 8'h00, "t2_turn1_gnt1");
      expect_at(1, S_A_PADT, 8'hFF, "t2_turn1_pad_t");
      expect_at(2, S_A_GNT1, 8'h00, "t2_turn2_gnt1");
      expect_at(2, S_A_PADT, 8'hFF, "t2_turn2_pad_t");
      expect_at(3, S_A_GNT1, 8'h01, "t2_gnt1");
      expect_at(3, S_A_GNT0, 8'h00, "t2_gnt0_off");
      expect_at(4, S_A_PADT, 8'h00, "t2_own1_pad_t");
      expect_at(4, S_A_PADI, 8'h5A, "t2_own1_pad_i");
      tick(5);

      // Reset in the middle of OWN1
      reset_n = 1'b0;
      expect_at(1, S_A_PADT, 8'hFF, "t6_rst_pad_t");
      expect_at(1, S_A_PADI, 8'h00, "t6_rst_pad_i");
      expect_at(1, S_A_GNT1, 8'h00, "t6_rst_gnt1");
      tick(1);
      reset_n = 1'b1;
      expect_at(1, S_A_GNT1, 8'h01, "t6_regrant1");
      expect_at(1, S_A_GNT0, 8'h00, "t6_gnt0");
      expect_at(2, S_A_PADT, 8'h00, "t6_pad_t");
      tick(3);

      // Input synchroniser latency
      pad_o = 8'h3C;
      expect_at(1, S_A_DI, 8'h00, "t5_di_early");
      expect_at(2, S_A_DI, 8'h3C, "t5_di");
      tick(4);

      // Open-drain pin on instance B
      reset_n = 1'b0;
      req1    = 1'b0;
      req0    = 1'b1;
      tick(1);
      reset_n = 1'b1;
      oe0     = 8'h01;
      do0     = 8'h00;
      expect_at(1, S_B_GNT0, 8'h01, "t3_gnt0");
      expect_at(2, S_B_PADT, 8'hFE, "t3_od_low_t");
      expect_at(2, S_B_PADI, 8'h00, "t3_od_low_i");
      tick(3);
      do0 = 8'h01;
      expect_at(1, S_B_PADT, 8'hFF, "t3_od_high_t");
      expect_at(1, S_B_PADI, 8'h00, "t3_od_high_i");
      tick(2);
      oe0 = 8'h02;
      do0 = 8'h02;
      expect_at(1, S_B_PADT, 8'hFD, "t3_pp_t");
      expect_at(1, S_B_PADI, 8'h02, "t3_pp_i");
      tick(2);

      // Hold limit: 4 own cycles, 2 turnaround cycles, alternating
      reset_n = 1'b0;
      req0    = 1'b0;
      req1    = 1'b0;
      tick(1);
      reset_n = 1'b1;
      req0    = 1'b1;
      req1    = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         int p;
         p = (e - 1) % 12;
         expect_at(e, S_B_GNT0, (p < 4) ? 8'h01 : 8'h00, "t4_gnt0");
         expect_at(e, S_B_GNT1, (p >= 6 && p < 10) ? 8'h01 : 8'h00, "t4_gnt1");
      end
      tick(15);

      for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
      chk("sb_drain", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
